// File: rtl/vga_sync_gen.sv
// Free-running VGA timing: pixel counts + active flags for the game logic, porch-corrected sync pins and blanked RGB.
// Latency: counts/flags 1 cycle, sync pins and RGB RGB_DELAY cycles behind counts; no backpressure, enable=0 freezes all state.
module vga_sync_gen #(
    parameter int TOTAL_COLS    = 800,
    parameter int TOTAL_ROWS    = 525,
    parameter int ACTIVE_COLS   = 640,
    parameter int ACTIVE_ROWS   = 480,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_WIDTH  = 96,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_WIDTH  = 2,
    parameter int SYNC_ACTIVE   = 0,
    parameter int RGB_DELAY     = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [3:0] in_Red,
    input  logic [3:0] in_Green,
    input  logic [3:0] in_Blue,
    output logic [9:0] column_count,
    output logic [9:0] row_count,
    output logic       out_Hsync,
    output logic       out_Vsync,
    output logic       frame_start,
    output logic [7:0] frame_count,
    output logic       vga_Hsync,
    output logic       vga_Vsync,
    output logic [3:0] vga_Red,
    output logic [3:0] vga_Green,
    output logic [3:0] vga_Blue
);

    generate
        if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS) begin : g_bad_h
            $error("vga_sync_gen: horizontal porch + sync exceeds TOTAL_COLS");
        end
        if (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS) begin : g_bad_v
            $error("vga_sync_gen: vertical porch + sync exceeds TOTAL_ROWS");
        end
        if (TOTAL_COLS > 1024 || TOTAL_ROWS > 1024) begin : g_bad_w
            $error("vga_sync_gen: timing does not fit 10-bit counters");
        end
        if (RGB_DELAY < 1) begin : g_bad_d
            $error("vga_sync_gen: RGB_DELAY must be at least 1");
        end
    endgenerate

    localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] ACT_COLS = 10'(ACTIVE_COLS);
    localparam logic [9:0] ACT_ROWS = 10'(ACTIVE_ROWS);
    localparam logic [9:0] H_START  = 10'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [9:0] H_END    = 10'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
    localparam logic [9:0] V_START  = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [9:0] V_END    = 10'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);
    localparam logic       SYNC_ON  = (SYNC_ACTIVE != 0);
    // The output registers form the last stage, so only RGB_DELAY-1 internal stages are needed.
    localparam int         PD       = (RGB_DELAY > 1) ? RGB_DELAY - 1 : 1;

    typedef struct packed {
        logic h;
        logic v;
        logic act;
    } sync_t;

    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic       hact_q, hact_d;
    logic       vact_q, vact_d;
    logic       fstart_q, fstart_d;
    logic [7:0] fcnt_q;
    logic       hs_q, vs_q;
    logic [3:0] red_q, green_q, blue_q;
    sync_t      cur, tail;
    sync_t      pipe_q [PD];

    always_comb begin
        col_d = col_q + 10'd1;
        row_d = row_q;
        if (col_q == COL_LAST) begin
            col_d = 10'd0;
            row_d = (row_q == ROW_LAST) ? 10'd0 : row_q + 10'd1;
        end
        hact_d   = (col_d < ACT_COLS);
        vact_d   = (row_d < ACT_ROWS);
        fstart_d = (col_d == 10'd0) && (row_d == 10'd0);
    end

    // Undelayed sync terms for the counts currently on the outputs.
    always_comb begin
        cur.h   = (col_q >= H_START) && (col_q <= H_END);
        cur.v   = (row_q >= V_START) && (row_q <= V_END);
        cur.act = hact_q & vact_q;
    end

    generate
        if (RGB_DELAY == 1) begin : g_tail_direct
            assign tail = cur;
        end else begin : g_tail_pipe
            assign tail = pipe_q[PD-1];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_q    <= COL_LAST;
            row_q    <= ROW_LAST;
            hact_q   <= 1'b0;
            vact_q   <= 1'b0;
            fstart_q <= 1'b0;
            fcnt_q   <= 8'd0;
            for (int i = 0; i < PD; i++) begin
                pipe_q[i] <= '0;
            end
            hs_q     <= ~SYNC_ON;
            vs_q     <= ~SYNC_ON;
            red_q    <= 4'h0;
            green_q  <= 4'h0;
            blue_q   <= 4'h0;
        end else if (enable) begin
            col_q    <= col_d;
            row_q    <= row_d;
            hact_q   <= hact_d;
            vact_q   <= vact_d;
            fstart_q <= fstart_d;
            if (fstart_d) begin
                fcnt_q <= fcnt_q + 8'd1;
            end
            pipe_q[0] <= cur;
            for (int i = 1; i < PD; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            hs_q    <= tail.h ? SYNC_ON : ~SYNC_ON;
            vs_q    <= tail.v ? SYNC_ON : ~SYNC_ON;
            red_q   <= tail.act ? in_Red   : 4'h0;
            green_q <= tail.act ? in_Green : 4'h0;
            blue_q  <= tail.act ? in_Blue  : 4'h0;
        end
    end

    assign column_count = col_q;
    assign row_count    = row_q;
    assign out_Hsync    = hact_q;
    assign out_Vsync    = vact_q;
    assign frame_start  = fstart_q;
    assign frame_count  = fcnt_q;
    assign vga_Hsync    = hs_q;
    assign vga_Vsync    = vs_q;
    assign vga_Red      = red_q;
    assign vga_Green    = green_q;
    assign vga_Blue     = blue_q;

endmodule
